// File: rtl/msg_tx.sv
// msg_tx: serializes one component write record per request into "b|f <id> <index> <value>\n" or "t\n".
// Define MSG_TX_TRIM_EN to suppress leading zeros on binary values; default sends all VAL_W digits.
module msg_tx #(
    parameter int IDX_W = 8,
    parameter int VAL_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [1:0]       req_id,
    input  logic [IDX_W-1:0] req_index,
    input  logic [VAL_W-1:0] req_value,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [3:0]       dbg_state
);

    localparam int VAL_DIG = (VAL_W * 3 + 7) / 8;
    localparam int IDX_DIG = (IDX_W * 3 + 7) / 8;
    localparam int VBCD_W  = 4 * VAL_DIG;
    localparam int IBCD_W  = 4 * IDX_DIG;
    localparam int VDD_W   = VBCD_W + VAL_W;
    localparam int IDD_W   = IBCD_W + IDX_W;
    localparam int PTR_W   = $clog2(VAL_W) + 1;
    localparam int CNT_W   = $clog2(VAL_W) + 1;

    localparam logic [1:0] K_B = 2'b00;
    localparam logic [1:0] K_F = 2'b01;
    localparam logic [1:0] K_T = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CONV, ST_KIND, ST_SP1, ST_ID1, ST_ID0,
        ST_SP2, ST_IDX, ST_SP3, ST_VAL, ST_NL
    } state_t;

    state_t             r_state;
    logic [1:0]         r_kind;
    logic [1:0]         r_id;
    logic [VAL_W-1:0]   r_val_bin;
    logic [VDD_W-1:0]   r_val_dd;
    logic [IDD_W-1:0]   r_idx_dd;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               r_req_ready;
    logic               r_busy;

    state_t             w_nxt_state;
    logic [PTR_W-1:0]   w_nxt_ptr;
    logic [7:0]         w_nxt_byte;
    logic [7:0]         w_cur_byte;
    logic [PTR_W-1:0]   w_idx_top;
    logic [PTR_W-1:0]   w_val_top;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [VDD_W-1:0] dd_val(input logic [VDD_W-1:0] x);
        logic [VDD_W-1:0] y;
        y = x;
        for (int i = 0; i < VAL_DIG; i++) begin
            if (y[VAL_W + i*4 +: 4] >= 4'd5) y[VAL_W + i*4 +: 4] = y[VAL_W + i*4 +: 4] + 4'd3;
        end
        return {y[VDD_W-2:0], 1'b0};
    endfunction

    function automatic logic [IDD_W-1:0] dd_idx(input logic [IDD_W-1:0] x);
        logic [IDD_W-1:0] y;
        y = x;
        for (int i = 0; i < IDX_DIG; i++) begin
            if (y[IDX_W + i*4 +: 4] >= 4'd5) y[IDX_W + i*4 +: 4] = y[IDX_W + i*4 +: 4] + 4'd3;
        end
        return {y[IDD_W-2:0], 1'b0};
    endfunction

    function automatic logic [PTR_W-1:0] top_nib_val(input logic [VBCD_W-1:0] b);
        logic [PTR_W-1:0] t;
        t = '0;
        for (int i = 0; i < VAL_DIG; i++) begin
            if (b[i*4 +: 4] != 4'd0) t = PTR_W'(i);
        end
        return t;
    endfunction

    function automatic logic [PTR_W-1:0] top_nib_idx(input logic [IBCD_W-1:0] b);
        logic [PTR_W-1:0] t;
        t = '0;
        for (int i = 0; i < IDX_DIG; i++) begin
            if (b[i*4 +: 4] != 4'd0) t = PTR_W'(i);
        end
        return t;
    endfunction

`ifdef MSG_TX_TRIM_EN
    function automatic logic [PTR_W-1:0] top_bit(input logic [VAL_W-1:0] v);
        logic [PTR_W-1:0] t;
        t = '0;
        for (int i = 0; i < VAL_W; i++) begin
            if (v[i]) t = PTR_W'(i);
        end
        return t;
    endfunction
`endif

    // ASCII byte presented while in state s with digit pointer p.
    function automatic logic [7:0] byte_of(input state_t s, input logic [PTR_W-1:0] p);
        logic [7:0] b;
        logic [3:0] nib;
        b   = 8'h00;
        nib = 4'd0;
        case (s)
            ST_KIND: b = (r_kind == K_B) ? 8'h62 : (r_kind == K_F) ? 8'h66 : 8'h74;
            ST_SP1, ST_SP2, ST_SP3: b = 8'h20;
            ST_ID1:  b = {7'b0011000, r_id[1]};
            ST_ID0:  b = {7'b0011000, r_id[0]};
            ST_IDX: begin
                for (int i = 0; i < IDX_DIG; i++) begin
                    if (p == PTR_W'(i)) nib = r_idx_dd[IDX_W + i*4 +: 4];
                end
                b = {4'h3, nib};
            end
            ST_VAL: begin
                if (r_kind == K_F) begin
                    for (int i = 0; i < VAL_DIG; i++) begin
                        if (p == PTR_W'(i)) nib = r_val_dd[VAL_W + i*4 +: 4];
                    end
                end else begin
                    for (int i = 0; i < VAL_W; i++) begin
                        if (p == PTR_W'(i)) nib = {3'b000, r_val_bin[i]};
                    end
                end
                b = {4'h3, nib};
            end
            ST_NL:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_idx_top = top_nib_idx(r_idx_dd[IDD_W-1 -: IBCD_W]);
`ifdef MSG_TX_TRIM_EN
    assign w_val_top = (r_kind == K_F) ? top_nib_val(r_val_dd[VDD_W-1 -: VBCD_W]) : top_bit(r_val_bin);
`else
    assign w_val_top = (r_kind == K_F) ? top_nib_val(r_val_dd[VDD_W-1 -: VBCD_W]) : PTR_W'(VAL_W - 1);
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        case (r_state)
            ST_KIND: w_nxt_state = (r_kind == K_T) ? ST_NL : ST_SP1;
            ST_SP1:  w_nxt_state = ST_ID1;
            ST_ID1:  w_nxt_state = ST_ID0;
            ST_ID0:  w_nxt_state = ST_SP2;
            ST_SP2: begin
                w_nxt_state = ST_IDX;
                w_nxt_ptr   = w_idx_top;
            end
            ST_IDX: begin
                if (r_ptr == '0) w_nxt_state = ST_SP3;
                else             w_nxt_ptr   = r_ptr - PTR_W'(1);
            end
            ST_SP3: begin
                w_nxt_state = ST_VAL;
                w_nxt_ptr   = w_val_top;
            end
            ST_VAL: begin
                if (r_ptr == '0) w_nxt_state = ST_NL;
                else             w_nxt_ptr   = r_ptr - PTR_W'(1);
            end
            ST_NL:   w_nxt_state = ST_IDLE;
            default: w_nxt_state = r_state;
        endcase
        w_nxt_byte = byte_of(w_nxt_state, w_nxt_ptr);
        w_cur_byte = byte_of(r_state, r_ptr);
    end

    // Handshakes: a request transfers when req_valid && req_ready at a rising edge, a byte when
    // tx_valid && tx_ready; once raised, tx_valid/tx_data hold until that byte transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_kind      <= '0;
            r_id        <= '0;
            r_val_bin   <= '0;
            r_val_dd    <= '0;
            r_idx_dd    <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_kind    <= req_kind;
                        r_id      <= req_id;
                        r_val_bin <= req_value;
                        r_val_dd  <= {{VBCD_W{1'b0}}, req_value};
                        r_idx_dd  <= {{IBCD_W{1'b0}}, req_index};
                        r_cnt     <= '0;
                        case (req_kind)
                            K_B, K_F: begin
                                r_state     <= ST_CONV;
                                r_busy      <= 1'b1;
                                r_req_ready <= 1'b0;
                            end
                            K_T: begin
                                r_state     <= ST_KIND;
                                r_busy      <= 1'b1;
                                r_req_ready <= 1'b0;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_CONV: begin
                    // The index engine stops after IDX_W steps so its BCD result holds for the frame.
                    if (r_cnt < CNT_W'(IDX_W)) r_idx_dd <= dd_idx(r_idx_dd);
                    if (r_kind == K_F) r_val_dd <= dd_val(r_val_dd);
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(VAL_W - 1)) r_state <= ST_KIND;
                end
                default: begin
                    if (!r_tx_valid) begin
                        r_tx_data  <= w_cur_byte;
                        r_tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        if (r_state == ST_NL) begin
                            r_state     <= ST_IDLE;
                            r_tx_valid  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state   <= w_nxt_state;
                            r_ptr     <= w_nxt_ptr;
                            r_tx_data <= w_nxt_byte;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_msg_tx.sv
// Self-checking bench for msg_tx: expected line bytes are queued at request time and
// popped against every transferred byte.
module tb_msg_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [1:0]  req_id;
  logic [7:0]  req_index;
  logic [63:0] req_value;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_hs = 0;
  bit hold_low = 1'b0;
  bit rand_rdy = 1'b0;
  logic [7:0] exp_q[$];

  msg_tx #(.IDX_W(8), .VAL_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_id(req_id), .req_index(req_index), .req_value(req_value),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic string fmt_line(input logic [1:0] k, input logic [1:0] id,
                                     input logic [7:0] idx, input logic [63:0] v);
    string vs;
`ifdef MSG_TX_TRIM_EN
    vs = $sformatf("%0b", v);
`else
    vs = $sformatf("%b", v);
`endif
    case (k)
      2'b00:   return {"b ", $sformatf("%b", id), " ", $sformatf("%0d", idx), " ", vs, "\n"};
      2'b01:   return {"f ", $sformatf("%b", id), " ", $sformatf("%0d", idx), " ",
                       $sformatf("%0d", v), "\n"};
      2'b10:   return "t\n";
      default: return "";
    endcase
  endfunction

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low)      tx_ready = 1'b0;
      else if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
      else               tx_ready = 1'b1;
    end
  end

  // scoreboard monitor
  initial begin : mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 64'(tx_data), 64'(e));
        end
        n_hs++;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [1:0] k, input logic [1:0] id, input logic [7:0] idx,
                      input logic [63:0] v, input bit chk_lat);
    string s;
    bit got;
    int lat;
    s = fmt_line(k, id, idx, v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    req_kind  = k;
    req_id    = id;
    req_index = idx;
    req_value = v;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    chk("req_ready_wait", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_kind  = 2'($urandom_range(0, 3));
    req_id    = 2'($urandom_range(0, 3));
    req_index = 8'($urandom_range(0, 255));
    req_value = {$urandom, $urandom};
    chk("busy_after_accept", 64'(busy), (k == 2'b11) ? 64'd0 : 64'd1);
    if (chk_lat && k != 2'b11) begin
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!tx_valid && lat < 200);
      chk("first_byte_lat", 64'(lat), (k == 2'b10) ? 64'd1 : 64'd65);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) break;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (n_hs >= target) break;
    end
    chk("reach_byte", 64'(n_hs >= target), 64'd1);
  endtask

  initial begin
    int base;
    rst = 1'b0;
    req_valid = 1'b0;
    req_kind = 2'b00;
    req_id = 2'b00;
    req_index = 8'd0;
    req_value = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'h00);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(2'b00, 2'b01, 8'd3, 64'd2, 1'b1);
    wait_done();
    send(2'b01, 2'b10, 8'd0, 64'd120, 1'b1);
    wait_done();
    send(2'b01, 2'b00, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done();
    send(2'b00, 2'b11, 8'd0, 64'd0, 1'b0);
    wait_done();
    send(2'b00, 2'b10, 8'd99, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done();
    send(2'b01, 2'b01, 8'd100, 64'd0, 1'b0);
    wait_done();

    // tick, then illegal kind, then two ticks back to back
    send(2'b10, 2'b00, 8'd0, 64'd0, 1'b1);
    wait_done();
    send(2'b11, 2'b01, 8'd5, 64'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("illegal_busy", 64'(busy), 64'd0);
      chk("illegal_tx_valid", 64'(tx_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(2'b10, 2'b00, 8'd0, 64'd0, 1'b0);
    send(2'b10, 2'b00, 8'd0, 64'd0, 1'b0);
    wait_done();

    // backpressure on the first index digit
    base = n_hs;
    send(2'b01, 2'b11, 8'd255, 64'd987654321, 1'b0);
    wait_hs(base + 5);
    hold_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(tx_valid), 64'd1);
      chk("bp_data", 64'(tx_data), 64'h32);
    end
    hold_low = 1'b0;
    wait_done();

    // asynchronous reset while value digits are going out
    base = n_hs;
    send(2'b01, 2'b01, 8'd7, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    wait_hs(base + 9);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(2'b00, 2'b10, 8'd200, 64'd5, 1'b1);
    wait_done();

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           {$urandom, $urandom} >> $urandom_range(0, 63), 1'b1);
      wait_done();
    end
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msg_tx.md
# msg_tx

Telemetry/command transmitter. It serializes one component write record per request into the ASCII line format consumed by the `io` command reader: `b <id> <index> <value>\n`, `f <id> <index> <value>\n` or `t\n`. Bytes leave on a valid/ready byte stream toward the client link. It sits between the component modules (`airflow`, `thrusters`, `solar`) and the host side, and produces exactly the grammar `io` parses.

## Interface
- `IDX_W`, 8, index width; decimal-encoded, at most 3 digits.
- `VAL_W`, 64, value width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_kind` input 2: 00 binary `b`, 01 float `f`, 10 tick `t`, 11 illegal.
- `req_id` input 2: component id, sent as 2 binary digits.
- `req_index` input IDX_W: field index, sent as unsigned decimal.
- `req_value` input VAL_W: payload; binary digits for `b`, unsigned decimal for `f`.
- `tx_data` output 8: ASCII byte.
- `tx_valid` output 1: `tx_data` valid.
- `tx_ready` input 1: byte consumed when `tx_valid && tx_ready` at a rising edge.
- `busy` output 1: frame in progress.

## Operation
- Request fields are captured at acceptance. Later input changes have no effect on the frame.
- States: IDLE, CONV, KIND, SP1, ID1, ID0, SP2, IDX, SP3, VAL, NL.
- IDLE: `req_ready`=1, `busy`=0. On acceptance:
  - kind 00 or 01 → CONV.
  - kind 10 → KIND.
  - kind 11 → request is consumed, no bytes are sent, stays in IDLE.
- CONV: double-dabble runs for exactly VAL_W cycles.
  - One engine converts the value (24 BCD nibbles are enough for 64 bits). It is used only for kind 01.
  - A second engine converts the index. It finishes after IDX_W cycles and holds its result.
  - At the end of CONV → KIND.
- Byte sequence:
  - KIND: `b`/`f`/`t` (0x62/0x66/0x74). For `t`, next state is NL.
  - SP1: 0x20.
  - ID1: `req_id[1]`. ID0: `req_id[0]`. Each digit is 0x30/0x31.
  - SP2: 0x20.
  - IDX: decimal digits, most significant first, leading zeros suppressed. Value 0 sends a single `0`.
  - SP3: 0x20.
  - VAL: for kind 01, decimal digits MSB-first with leading zeros suppressed (0 → `0`). For kind 00, binary digits (see Configuration).
  - NL: 0x0A, then → IDLE.
- Each byte state advances only on a `tx_valid && tx_ready` handshake.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `req_ready`=1, `busy`=0, state IDLE.
- Reset is asynchronous and takes effect mid-frame. The partial frame is abandoned and `tx_valid` drops immediately. No NL is sent.
- Latency:
  - Accept at edge N, kinds 00/01: first byte valid from edge N+VAL_W+1.
  - Accept at edge N, kind 10: first byte valid from edge N+1.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable.
- With `tx_ready` held high, one byte is sent per cycle and there are no bubbles inside a frame.
- After NL completes at edge M, `req_ready`=1 from edge M. Back-to-back acceptance at edge M+1 is legal.
- `req_ready`=0 for the whole frame. No queuing.
- `tx_valid` is registered. `tx_ready` has no combinational path to `tx_valid` or `tx_data`.

## Configuration
- `MSG_TX_TRIM_EN` defined: binary values have leading zeros suppressed. Value 0 sends a single `0`.
- `MSG_TX_TRIM_EN` undefined: binary values are sent at full VAL_W digits, MSB first. Decimal encoding of index and float values is unchanged in both modes.

## Test plan
- Binary write, TRIM_EN on: kind 00, id 01, index 3, value 2 → bytes 62 20 30 31 20 33 20 31 30 0A. First byte at acceptance+65 cycles.
- Float write: kind 01, id 10, index 0, value 120 → "f 10 0 120\n".
- Float max: value 2^64-1, index 255 → "f 00 255 18446744073709551615\n".
- Tick then illegal: kind 10 → "t\n" with first byte at acceptance+1. A following kind 11 request → accepted, no bytes, `busy` stays 0.
- Backpressure: hold `tx_ready` low 5 cycles during the IDX byte → `tx_data` stable, no byte dropped or duplicated, full line intact.
- Reset mid-VAL: assert `rst` low → `tx_valid`=0 and `busy`=0 asynchronously. After release, a new request produces a complete, correct line.
